// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller that feeds a combinational 32-bit ALU from a
// 16-entry register file.
// Latency: done pulses two cycles after acceptance; rf[rd] updates at the end
// of that cycle. Throughput is one instruction per 3 cycles.
// Backpressure: instr_ready is high only in IDLE; host writes are never stalled.
// Ports: clk/rst (sync, active-high); instr_valid/instr_ready/instr handshake;
//   alu_a/alu_b/alu_op registered to the ALU, alu_result/alu_apsr back from it;
//   apsr_q latched NZC flags; done writeback pulse; div0_err sticky trap flag;
//   host_we/host_waddr/host_wdata rf write port; dbg_raddr/dbg_rdata rf read.
// Optional macro ALU_DIV0_TRAP_EN: divide by zero suppresses writeback and
//   sets div0_err. Without it, div-by-zero writes 0 and Z-only flags.
module alu_issue_ctrl #(
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] RF_RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [31:0]       alu_apsr,
  output logic [31:0]       apsr_q,
  output logic              done,
  output logic              div0_err,
  input  logic              host_we,
  input  logic [3:0]        host_waddr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic [3:0]        dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata
);

  localparam logic [3:0] OP_DIV = 4'b0011;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t            state, state_nxt;
  logic [15:0]       instr_q;
  logic [DATA_W-1:0] rf [16];

  logic [3:0] op_q, rd_q, rs1_q, rs2_q;
  assign op_q  = instr_q[15:12];
  assign rd_q  = instr_q[11:8];
  assign rs1_q = instr_q[7:4];
  assign rs2_q = instr_q[3:0];

  // alu_b holds rf[rs2] as read in EXEC, so this is the EXEC-time check
  // carried into WB without an extra flop.
  logic div0_wb;
  assign div0_wb = (alu_op == OP_DIV) && (alu_b == '0);

  logic              wb_rf_we, wb_apsr_we;
  logic [DATA_W-1:0] wb_data;
  logic [31:0]       wb_apsr;

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    done        = 1'b0;
    wb_rf_we    = 1'b0;
    wb_apsr_we  = 1'b0;
    wb_data     = alu_result;
    wb_apsr     = {alu_apsr[31:29], 29'b0};
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = EXEC;
      end
      EXEC: state_nxt = WB;
      WB: begin
        done       = 1'b1;
        wb_rf_we   = 1'b1;
        wb_apsr_we = 1'b1;
        state_nxt  = IDLE;
        if (div0_wb) begin
`ifdef ALU_DIV0_TRAP_EN
          wb_rf_we   = 1'b0;
          wb_apsr_we = 1'b0;
`else
          wb_data = '0;
          wb_apsr = 32'h4000_0000;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      instr_q <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= '0;
      apsr_q  <= '0;
      for (int i = 0; i < 16; i++) rf[i] <= RF_RST_VAL;
    end else begin
      state <= state_nxt;
      if (instr_valid && instr_ready) instr_q <= instr;
      if (state == EXEC) begin
        alu_a  <= rf[rs1_q];
        alu_b  <= rf[rs2_q];
        alu_op <= op_q;
      end
      // Writeback is assigned after the host write so it wins on the same rd.
      if (host_we)    rf[host_waddr] <= host_wdata;
      if (wb_rf_we)   rf[rd_q]       <= wb_data;
      if (wb_apsr_we) apsr_q         <= wb_apsr;
    end
  end

`ifdef ALU_DIV0_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst)                           div0_err <= 1'b0;
    else if ((state == WB) && div0_wb) div0_err <= 1'b1;
  end
`else
  assign div0_err = 1'b0;
`endif

  assign dbg_rdata = rf[dbg_raddr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: provides a behavioural ALU, table-driven vectors,
// hand sequences for back-to-back, divide-by-zero and mid-op reset, and a
// randomized phase checked against a register-file/flag reference model.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [31:0] alu_a, alu_b, alu_result, alu_apsr, apsr_q;
  logic [3:0]  alu_op;
  logic        done, div0_err, host_we;
  logic [3:0]  host_waddr, dbg_raddr;
  logic [31:0] host_wdata, dbg_rdata;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_apsr(alu_apsr), .apsr_q(apsr_q), .done(done),
    .div0_err(div0_err), .host_we(host_we), .host_waddr(host_waddr),
    .host_wdata(host_wdata), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  // ALU: 0 add, 1 sub, 2 and, 3 signed div, 4 or, 5 xor, else pass a.
  // C is carry-out for add and not-borrow for sub. Div by zero returns junk.
  typedef struct { logic [31:0] res; logic [31:0] apsr; } alu_out_t;

  function automatic alu_out_t alu_ref(input logic [31:0] a, input logic [31:0] b,
                                       input logic [3:0] op);
    alu_out_t o;
    logic [32:0] s;
    logic c;
    c = 1'b0;
    case (op)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; o.res = s[31:0]; c = s[32]; end
      4'd1: begin o.res = a - b; c = (a >= b); end
      4'd2: o.res = a & b;
      4'd3: begin
        if (b == 0) o.res = 32'hDEAD_BEEF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) o.res = a;
        else o.res = $signed(a) / $signed(b);
      end
      4'd4: o.res = a | b;
      4'd5: o.res = a ^ b;
      default: o.res = a;
    endcase
    if (op == 4'd3 && b == 0) o.apsr = 32'h8000_0000;
    else o.apsr = {o.res[31], (o.res == 0), c, 29'b0};
    return o;
  endfunction

  always_comb begin
    alu_out_t o;
    o = alu_ref(alu_a, alu_b, alu_op);
    alu_result = o.res;
    alu_apsr   = o.apsr;
  end

  int total = 0;
  int bad   = 0;

  logic [31:0] mrf [16];
  logic [31:0] m_apsr;
  logic        m_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mrf[i] = 32'h0;
    m_apsr = 32'h0;
    m_err  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic host_write(input logic [3:0] a, input logic [31:0] d);
    host_we = 1'b1; host_waddr = a; host_wdata = d;
    step();
    host_we = 1'b0;
    mrf[a] = d;
  endtask

  task automatic rd_chk(input string nm, input logic [3:0] a, input logic [31:0] exp);
    dbg_raddr = a;
    #1;
    chk(nm, dbg_rdata, exp);
  endtask

  // Issues one instruction; returns with the writeback edge just passed.
  task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                       input logic [3:0] rs2, output int wait_c);
    alu_out_t r;
    int lat, busy;
    r = alu_ref(mrf[rs1], mrf[rs2], op);
    instr = {op, rd, rs1, rs2};
    instr_valid = 1'b1;
    wait_c = 0;
    while (!instr_ready && wait_c < 20) begin step(); wait_c++; end
    if (!instr_ready) chk("accept_timeout", 32'(instr_ready), 32'd1);
    step();
    instr_valid = 1'b0;
    lat = 1;
    busy = instr_ready ? 0 : 1;
    while (!done && lat < 10) begin
      step();
      lat++;
      if (!instr_ready) busy++;
    end
    chk("done_latency", lat, 2);
    chk("ready_low_cycles", busy, 2);
    if (op == 4'd3 && mrf[rs2] == 0) begin
`ifdef ALU_DIV0_TRAP_EN
      m_err = 1'b1;
`else
      mrf[rd] = 32'h0;
      m_apsr  = 32'h4000_0000;
`endif
    end else begin
      mrf[rd] = r.res;
      m_apsr  = r.apsr;
    end
    step();
    chk("done_one_cycle", 32'(done), 32'd0);
    rd_chk("wb_value", rd, mrf[rd]);
    chk("apsr", apsr_q, m_apsr);
    chk("div0_err", 32'(div0_err), 32'(m_err));
  endtask

  typedef struct {
    logic [3:0]  op, rd, rs1, rs2;
    logic [31:0] a, b, exp_res, exp_apsr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int w;
    rst = 1'b0; instr_valid = 1'b0; instr = '0; host_we = 1'b0;
    host_waddr = '0; host_wdata = '0; dbg_raddr = '0;

    vecs[0] = '{4'd0, 4'd3,  4'd1,  4'd2,  32'd5,          32'd7,          32'd12,         32'h0};
    vecs[1] = '{4'd0, 4'd4,  4'd1,  4'd2,  32'h8000_0000,  32'h8000_0000,  32'h0,          32'h6000_0000};
    vecs[2] = '{4'd1, 4'd5,  4'd1,  4'd2,  32'd3,          32'd5,          32'hFFFF_FFFE,  32'h8000_0000};
    vecs[3] = '{4'd1, 4'd5,  4'd1,  4'd2,  32'd5,          32'd5,          32'h0,          32'h6000_0000};
    vecs[4] = '{4'd0, 4'd10, 4'd11, 4'd11, 32'd21,         32'd21,         32'd42,         32'h0};
    vecs[5] = '{4'd3, 4'd8,  4'd1,  4'd2,  32'd100,        32'd7,          32'd14,         32'h0};
    vecs[6] = '{4'd2, 4'd12, 4'd1,  4'd2,  32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  32'h0};

    // Reset state
    do_reset();
    for (int i = 0; i < 16; i++) rd_chk("rst_rf", 4'(i), 32'h0);
    chk("rst_apsr", apsr_q, 32'h0);
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_alu_a", alu_a, 32'h0);
    chk("rst_alu_op", 32'(alu_op), 32'h0);
    chk("rst_div0", 32'(div0_err), 32'd0);

    // Table-driven vectors
    for (int i = 0; i < 7; i++) begin
      host_write(vecs[i].rs1, vecs[i].a);
      host_write(vecs[i].rs2, vecs[i].b);
      issue(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, w);
      rd_chk("vec_res", vecs[i].rd, vecs[i].exp_res);
      chk("vec_apsr", apsr_q, vecs[i].exp_apsr);
    end

    // Back-to-back with read-after-write of the previous rd
    host_write(4'd1, 32'd3);
    host_write(4'd2, 32'd4);
    issue(4'd0, 4'd6, 4'd1, 4'd2, w);
    issue(4'd0, 4'd7, 4'd6, 4'd6, w);
    chk("b2b_wait", w, 0);
    rd_chk("b2b_r7", 4'd7, 32'd14);

    // Host write to rd during WB loses to the writeback
    host_write(4'd1, 32'd1);
    host_write(4'd2, 32'd2);
    instr = {4'd0, 4'd13, 4'd1, 4'd2};
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    host_we = 1'b1; host_waddr = 4'd13; host_wdata = 32'h7777;
    step();
    host_we = 1'b0;
    mrf[13] = 32'd3;
    m_apsr  = 32'h0;
    rd_chk("wb_beats_host", 4'd13, 32'd3);

    // Divide by zero
    host_write(4'd1, 32'd10);
    host_write(4'd2, 32'd0);
    host_write(4'd8, 32'h55);
    issue(4'd3, 4'd8, 4'd1, 4'd2, w);
`ifdef ALU_DIV0_TRAP_EN
    rd_chk("div0_r8", 4'd8, 32'h55);
    chk("div0_flag", 32'(div0_err), 32'd1);
`else
    rd_chk("div0_r8", 4'd8, 32'h0);
    chk("div0_apsr", apsr_q, 32'h4000_0000);
    chk("div0_flag", 32'(div0_err), 32'd0);
`endif
    host_write(4'd2, 32'd1);
    issue(4'd0, 4'd9, 4'd1, 4'd2, w);
`ifdef ALU_DIV0_TRAP_EN
    chk("div0_sticky", 32'(div0_err), 32'd1);
`else
    chk("div0_sticky", 32'(div0_err), 32'd0);
`endif

    // Randomized stimulus against the model
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < 2; k++)
        host_write(4'($urandom_range(0, 15)),
                   ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom);
      issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), w);
    end
    for (int i = 0; i < 16; i++) rd_chk("rand_rf", 4'(i), mrf[i]);

    // Reset during EXEC abandons the instruction
    host_write(4'd9, 32'h33);
    instr = {4'd0, 4'd9, 4'd1, 4'd2};
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    chk("exec_busy", 32'(instr_ready), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_ready", 32'(instr_ready), 32'd1);
    step();
    chk("midrst_done2", 32'(done), 32'd0);
    chk("midrst_ready2", 32'(instr_ready), 32'd1);
    rd_chk("midrst_r9", 4'd9, 32'h0);
    chk("midrst_apsr", apsr_q, 32'h0);
    chk("midrst_div0", 32'(div0_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
